// File: rtl/lru_stamp_table.sv
// Exact-LRU recency tracker for one cache set: one stamp per way (0 = least recent,
// WAYS-1 = most recent), updated by touch/alloc/inval/flush, with a registered alloc victim.

module lru_min_finder #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N*W-1:0] values,
  input  logic [N*W-1:0] indices,
  output logic [W-1:0]   min_index
);

  logic [W-1:0] min_value;

  // Stamps are a permutation, so a strict less-than scan never meets a tie.
  always_comb begin
    min_value = values[W-1:0];
    min_index = indices[W-1:0];
    for (int i = 1; i < N; i++) begin
      if (values[i*W +: W] < min_value) begin
        min_value = values[i*W +: W];
        min_index = indices[i*W +: W];
      end
    end
  end

endmodule

module lru_stamp_table #(
  parameter int WAYS        = 4,
  parameter int STAMP_WIDTH = $clog2(WAYS)
) (
  input  logic                        i_clk,
  input  logic                        i_reset_n,
  input  logic                        i_touch,
  input  logic [STAMP_WIDTH-1:0]      i_touch_way,
  input  logic                        i_alloc,
  input  logic                        i_inval,
  input  logic [STAMP_WIDTH-1:0]      i_inval_way,
  input  logic                        i_flush,
  output logic                        o_victim_valid,
  output logic [STAMP_WIDTH-1:0]      o_victim_way,
  output logic [STAMP_WIDTH-1:0]      o_lru_way,
  output logic [WAYS*STAMP_WIDTH-1:0] o_stamps
);

  localparam logic [STAMP_WIDTH-1:0] MAX_STAMP = STAMP_WIDTH'(WAYS - 1);

  logic [STAMP_WIDTH-1:0]      stamp_q [WAYS];
  logic [STAMP_WIDTH-1:0]      stamp_d [WAYS];
  logic [WAYS*STAMP_WIDTH-1:0] stamps_flat;
  logic [WAYS*STAMP_WIDTH-1:0] index_flat;
  logic [STAMP_WIDTH-1:0]      event_way;
  logic [STAMP_WIDTH-1:0]      old_stamp;
  logic                        promote;

  for (genvar g = 0; g < WAYS; g++) begin : g_flatten
    assign stamps_flat[g*STAMP_WIDTH +: STAMP_WIDTH] = stamp_q[g];
    assign index_flat[g*STAMP_WIDTH +: STAMP_WIDTH]  = STAMP_WIDTH'(g);
  end

  assign o_stamps = stamps_flat;

  lru_min_finder #(
    .N (WAYS),
    .W (STAMP_WIDTH)
  ) u_min_finder (
    .values    (stamps_flat),
    .indices   (index_flat),
    .min_index (o_lru_way)
  );

  // Alloc and touch share the promote rule; inval uses the mirror-image demote rule.
  always_comb begin
    stamp_d   = stamp_q;
    event_way = i_touch_way;
    if (i_alloc) begin
      event_way = o_lru_way;
    end else if (i_inval) begin
      event_way = i_inval_way;
    end
    old_stamp = stamp_q[event_way];
    promote   = i_alloc || (!i_inval && i_touch);
    for (int i = 0; i < WAYS; i++) begin
      if (i_flush) begin
        stamp_d[i] = STAMP_WIDTH'(i);
      end else if (promote) begin
        if (event_way == STAMP_WIDTH'(i)) begin
          stamp_d[i] = MAX_STAMP;
        end else if (stamp_q[i] > old_stamp) begin
          stamp_d[i] = stamp_q[i] - 1'b1;
        end
      end else if (i_inval) begin
        if (event_way == STAMP_WIDTH'(i)) begin
          stamp_d[i] = '0;
        end else if (stamp_q[i] < old_stamp) begin
          stamp_d[i] = stamp_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < WAYS; i++) begin
        stamp_q[i] <= STAMP_WIDTH'(i);
      end
      o_victim_valid <= 1'b0;
      o_victim_way   <= '0;
    end else begin
      stamp_q        <= stamp_d;
      o_victim_valid <= i_alloc && !i_flush;
      if (i_flush) begin
        o_victim_way <= '0;
      end else if (i_alloc) begin
        o_victim_way <= o_lru_way;
      end
    end
  end

endmodule

// File: tb/tb_lru_stamp_table.sv
// Randomized and directed bench for lru_stamp_table against a recency-list model
// (queue ordered least-recent to most-recent; a way's stamp is its queue position).

module tb_lru_stamp_table;

  localparam int WAYS = 4;
  localparam int SW   = 2;

  logic              i_clk = 1'b0;
  logic              i_reset_n = 1'b0;
  logic              i_touch = 1'b0;
  logic [SW-1:0]     i_touch_way = '0;
  logic              i_alloc = 1'b0;
  logic              i_inval = 1'b0;
  logic [SW-1:0]     i_inval_way = '0;
  logic              i_flush = 1'b0;
  logic              o_victim_valid;
  logic [SW-1:0]     o_victim_way;
  logic [SW-1:0]     o_lru_way;
  logic [WAYS*SW-1:0] o_stamps;

  int   tests_run = 0;
  int   tests_failed = 0;
  int   model_q[$];
  logic exp_valid;
  int   exp_victim;

  always #5 i_clk = ~i_clk;

  lru_stamp_table #(.WAYS(WAYS)) dut (
    .i_clk          (i_clk),
    .i_reset_n      (i_reset_n),
    .i_touch        (i_touch),
    .i_touch_way    (i_touch_way),
    .i_alloc        (i_alloc),
    .i_inval        (i_inval),
    .i_inval_way    (i_inval_way),
    .i_flush        (i_flush),
    .o_victim_valid (o_victim_valid),
    .o_victim_way   (o_victim_way),
    .o_lru_way      (o_lru_way),
    .o_stamps       (o_stamps)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  function automatic void model_reset();
    model_q.delete();
    for (int i = 0; i < WAYS; i++) model_q.push_back(i);
    exp_valid  = 1'b0;
    exp_victim = 0;
  endfunction

  function automatic void model_move(input int way, input bit to_mru);
    for (int p = 0; p < model_q.size(); p++) begin
      if (model_q[p] == way) begin
        model_q.delete(p);
        break;
      end
    end
    if (to_mru) model_q.push_back(way);
    else model_q.push_front(way);
  endfunction

  function automatic int model_stamp(input int way);
    for (int p = 0; p < model_q.size(); p++) begin
      if (model_q[p] == way) return p;
    end
    return -1;
  endfunction

  // Drive one cycle of events, advance the model, and land on the following negedge.
  task automatic applyStimulus(input bit flush, input bit alloc, input bit inval, input int inval_way,
                               input bit touch, input int touch_way);
    i_flush     = flush;
    i_alloc     = alloc;
    i_inval     = inval;
    i_inval_way = SW'(inval_way);
    i_touch     = touch;
    i_touch_way = SW'(touch_way);
    exp_valid   = 1'b0;
    if (flush) begin
      model_reset();
    end else if (alloc) begin
      exp_victim = model_q[0];
      exp_valid  = 1'b1;
      model_move(exp_victim, 1'b1);
    end else if (inval) begin
      model_move(inval_way, 1'b0);
    end else if (touch) begin
      model_move(touch_way, 1'b1);
    end
    @(posedge i_clk);
    @(negedge i_clk);
    i_flush = 1'b0;
    i_alloc = 1'b0;
    i_inval = 1'b0;
    i_touch = 1'b0;
  endtask

  task automatic check_all(input string ctx);
    logic [WAYS-1:0] seen;
    seen = '0;
    for (int i = 0; i < WAYS; i++) begin
      checkOutput($sformatf("%s stamp[%0d]", ctx, i), 32'(o_stamps[i*SW +: SW]), 32'(model_stamp(i)));
      seen[o_stamps[i*SW +: SW]] = 1'b1;
    end
    checkOutput({ctx, " perm"}, 32'(seen), 32'({WAYS{1'b1}}));
    checkOutput({ctx, " lru"}, 32'(o_lru_way), 32'(model_q[0]));
    checkOutput({ctx, " valid"}, 32'(o_victim_valid), 32'(exp_valid));
    if (exp_valid) checkOutput({ctx, " victim"}, 32'(o_victim_way), 32'(exp_victim));
  endtask

  initial begin
    int exp_seq[5];
    exp_seq = '{0, 1, 2, 3, 0};
    model_reset();

    repeat (2) @(negedge i_clk);
    checkOutput("reset stamps", 32'(o_stamps), 32'h00E4);
    checkOutput("reset valid", 32'(o_victim_valid), 32'd0);
    checkOutput("reset victim", 32'(o_victim_way), 32'd0);
    i_reset_n = 1'b1;
    @(negedge i_clk);
    check_all("post-reset");

    // Single alloc, touch reorder, second alloc
    applyStimulus(0, 1, 0, 0, 0, 0);
    check_all("alloc1");
    checkOutput("alloc1 stamps", 32'(o_stamps), 32'h0093);
    applyStimulus(0, 0, 0, 0, 1, 2);
    check_all("touch2");
    checkOutput("touch2 stamps", 32'(o_stamps), 32'h0072);
    applyStimulus(0, 1, 0, 0, 0, 0);
    check_all("alloc2");
    checkOutput("alloc2 victim", 32'(o_victim_way), 32'd1);

    // Invalidate promotes a way to victim
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 2);
    applyStimulus(0, 0, 1, 2, 0, 0);
    check_all("inval2");
    checkOutput("inval2 stamps", 32'(o_stamps), 32'h0087);
    checkOutput("inval2 lru", 32'(o_lru_way), 32'd2);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("inval alloc victim", 32'(o_victim_way), 32'd2);

    // Back-to-back allocs from the reset ordering
    applyStimulus(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, 1, 0, 0, 0, 0);
      check_all($sformatf("b2b%0d", k));
      checkOutput($sformatf("b2b%0d victim", k), 32'(o_victim_way), 32'(exp_seq[k]));
    end

    // Simultaneous events
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 1, 3);
    check_all("alloc+touch");
    checkOutput("alloc+touch stamps", 32'(o_stamps), 32'h0093);
    applyStimulus(1, 1, 0, 0, 0, 0);
    check_all("flush+alloc");
    checkOutput("flush+alloc valid", 32'(o_victim_valid), 32'd0);
    checkOutput("flush+alloc stamps", 32'(o_stamps), 32'h00E4);

    // Async reset in the middle of a victim pulse
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    i_alloc = 1'b1;
    @(posedge i_clk);
    #2;
    checkOutput("pre-reset valid", 32'(o_victim_valid), 32'd1);
    i_reset_n = 1'b0;
    #1;
    checkOutput("async valid", 32'(o_victim_valid), 32'd0);
    checkOutput("async stamps", 32'(o_stamps), 32'h00E4);
    checkOutput("async lru", 32'(o_lru_way), 32'd0);
    i_alloc = 1'b0;
    model_reset();
    @(posedge i_clk);
    #1;
    checkOutput("held stamps", 32'(o_stamps), 32'h00E4);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    @(negedge i_clk);
    check_all("after async");

    // Randomized mix of events against the model
    for (int n = 0; n < 400; n++) begin
      applyStimulus($urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 2) == 0, int'($urandom_range(0, WAYS - 1)),
                    $urandom_range(0, 1) == 0, int'($urandom_range(0, WAYS - 1)));
      check_all($sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
